spi_burst_memory: RTL and testbench

SPI_BURST_MEMORY -- requirements
Module: spi_burst_memory

---
 rtl/spi_mem_pkg.sv | 14 +
 rtl/spi_pin_sync.sv | 42 ++++
 rtl/spi_burst_memory.sv | 175 +++++++++++++++++
 tb/tb_spi_burst_memory.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// Shared types and default widths for the SPI burst memory slice.
package spi_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for one raw SPI pin, plus registered rise/fall pulses.
module spi_pin_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q, sync_q, prev_q;
    logic rise_q, rise_d, fall_q, fall_d;

    always_comb begin
        rise_d = sync_q & ~prev_q;
        fall_d = ~sync_q & prev_q;
    end

    // Pulses are registered so pin-to-pulse latency is three clocks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= pin;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level = sync_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/spi_burst_memory.sv
// SPI mode-0 slave with burst read/write access to an internal word memory.
// Optional macro SPI_BURST_MEMORY_FAULT_EN: fault_pin inverts bit 0 of committed words.
module spi_burst_memory
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_pin,
    input  logic       cs_pin,
    input  logic       mosi_pin,
    output logic       miso_pin,
    output logic       miso_oe,
    input  logic       fault_pin,
    output logic [3:0] leds
);

    localparam int CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic [3:0] sync_unused;

    spi_pin_sync #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .pin(sclk_pin),
        .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_pin_sync #(.RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst_n(rst_n), .pin(cs_pin),
        .level(cs_s), .rise(cs_rise), .fall(cs_fall)
    );
    spi_pin_sync #(.RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst_n(rst_n), .pin(mosi_pin),
        .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );
    assign sync_unused = {sclk_s, cs_rise, mosi_rise, mosi_fall};

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   cmd_sr_q, cmd_sr_d;
    logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                miso_q, miso_d;
    logic                rw_q, rw_d;
    logic                wr_pend_q, wr_pend_d;
    logic                rd_req_q, rd_req_d;
    logic                rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0]   rd_data_q;
    logic [DATA_W-1:0]   fault_mask;
    logic [DATA_W-1:0]   mem [DEPTH];

`ifdef SPI_BURST_MEMORY_FAULT_EN
    assign fault_mask = DATA_W'(fault_pin);
`else
    logic unused_fault;
    assign fault_mask   = '0;
    assign unused_fault = fault_pin;
`endif

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        addr_d    = addr_q;
        cmd_sr_d  = cmd_sr_q;
        rx_sr_d   = rx_sr_q;
        tx_sr_d   = tx_sr_q;
        wr_data_d = wr_data_q;
        miso_d    = miso_q;
        rw_d      = rw_q;
        wr_pend_d = 1'b0;
        rd_req_d  = 1'b0;
        rd_vld_d  = rd_req_q;

        // A pending commit finishes regardless of state, so a CS release
        // that coincides with it cannot lose the word.
        if (wr_pend_q) addr_d = next_addr(addr_q);
        if (rd_vld_q)  tx_sr_d = rd_data_q;

        unique case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                miso_d    = 1'b0;
                if (cs_fall) state_d = ST_CMD;
            end
            ST_CMD: if (sclk_rise) begin
                if (bit_cnt_q == CNT_W'(ADDR_W)) begin
                    addr_d    = ADDR_W'(32'(cmd_sr_q) % 32'(DEPTH));
                    rw_d      = mosi_s;
                    rd_req_d  = mosi_s;
                    state_d   = mosi_s ? ST_READ : ST_WRITE;
                    bit_cnt_d = '0;
                end else begin
                    cmd_sr_d  = ADDR_W'({cmd_sr_q, mosi_s});
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_READ: if (sclk_fall) begin
                miso_d  = tx_sr_q[DATA_W-1];
                tx_sr_d = tx_sr_q << 1;
                if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                    bit_cnt_d = '0;
                    addr_d    = next_addr(addr_q);
                    rd_req_d  = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_WRITE: if (sclk_rise) begin
                rx_sr_d = DATA_W'({rx_sr_q, mosi_s});
                if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                    wr_pend_d = 1'b1;
                    wr_data_d = rx_sr_d ^ fault_mask;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cs_s) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            addr_q    <= '0;
            cmd_sr_q  <= '0;
            rx_sr_q   <= '0;
            tx_sr_q   <= '0;
            wr_data_q <= '0;
            miso_q    <= 1'b0;
            rw_q      <= 1'b0;
            wr_pend_q <= 1'b0;
            rd_req_q  <= 1'b0;
            rd_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            cmd_sr_q  <= cmd_sr_d;
            rx_sr_q   <= rx_sr_d;
            tx_sr_q   <= tx_sr_d;
            wr_data_q <= wr_data_d;
            miso_q    <= miso_d;
            rw_q      <= rw_d;
            wr_pend_q <= wr_pend_d;
            rd_req_q  <= rd_req_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

    // Memory contents survive reset; reset only blocks an in-flight commit.
    always_ff @(posedge clk) begin
        if (rst_n && wr_pend_q) mem[addr_q] <= wr_data_q;
        if (rd_req_q) rd_data_q <= mem[addr_q];
    end

    assign miso_oe  = (state_q == ST_READ);
    assign miso_pin = miso_q & miso_oe;
    assign leds     = {state_q != ST_IDLE, rw_q, state_q};

endmodule

// File: tb/tb_spi_burst_memory.sv
// Directed bench for spi_burst_memory: SPI bit-banged transfers with fixed expected data.
module tb_spi_burst_memory;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk_pin = 1'b0;
    logic       cs_pin = 1'b1;
    logic       mosi_pin = 1'b0;
    logic       fault_pin = 1'b0;
    logic       miso_pin;
    logic       miso_oe;
    logic [3:0] leds;

    int total = 0;
    int bad   = 0;

    spi_burst_memory #(.ADDR_W(7), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .sclk_pin(sclk_pin), .cs_pin(cs_pin),
        .mosi_pin(mosi_pin), .miso_pin(miso_pin), .miso_oe(miso_oe),
        .fault_pin(fault_pin), .leds(leds)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_h();
        wait_clk(8);
    endtask

    task automatic send_bit(input logic b);
        mosi_pin = b;
        wait_h();
        sclk_pin = 1'b1;
        wait_h();
        sclk_pin = 1'b0;
    endtask

    task automatic send_cmd(input logic [6:0] addr, input logic rw);
        cs_pin = 1'b0;
        wait_h();
        for (int i = 6; i >= 0; i--) send_bit(addr[i]);
        send_bit(rw);
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
    endtask

    // Samples one byte from miso; each sample follows a falling edge.
    task automatic recv_byte(input string tag, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            wait_h();
            d[i] = miso_pin;
            check({tag, "_oe"}, 32'(miso_oe), 32'd1);
            sclk_pin = 1'b1;
            wait_h();
            sclk_pin = 1'b0;
        end
    endtask

    task automatic end_xfer();
        wait_h();
        cs_pin = 1'b1;
        wait_h();
        wait_h();
    endtask

    task automatic read_word(input logic [6:0] addr, input string tag, input logic [7:0] exp);
        logic [7:0] d;
        send_cmd(addr, 1'b1);
        recv_byte(tag, d);
        check(tag, 32'(d), 32'(exp));
        end_xfer();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] exp_pat;

        wait_clk(4);
        check("rst_miso", 32'(miso_pin), 32'd0);
        check("rst_oe", 32'(miso_oe), 32'd0);
        check("rst_leds", 32'(leds), 32'h0);
        rst_n = 1'b1;
        wait_clk(4);

        // Single write of 0xA5 to 0x05, then read it back bit by bit.
        send_cmd(7'h05, 1'b0);
        wait_clk(2);
        check("wr_leds", 32'(leds), 32'hB);
        send_byte(8'hA5);
        end_xfer();

        send_cmd(7'h05, 1'b1);
        wait_clk(2);
        check("rd_leds", 32'(leds), 32'hE);
        exp_pat = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            wait_h();
            check("rd05_bit", 32'(miso_pin), 32'(exp_pat[i]));
            check("rd05_oe", 32'(miso_oe), 32'd1);
            sclk_pin = 1'b1;
            wait_h();
            sclk_pin = 1'b0;
        end
        end_xfer();
        check("idle_oe", 32'(miso_oe), 32'd0);

        // Burst write wrapping from the top address to 0.
        send_cmd(7'h7F, 1'b0);
        send_byte(8'h11);
        send_byte(8'h22);
        end_xfer();
        send_cmd(7'h7F, 1'b1);
        recv_byte("burst0", d);
        check("burst_7f", 32'(d), 32'h11);
        recv_byte("burst1", d);
        check("burst_00", 32'(d), 32'h22);
        end_xfer();
        read_word(7'h00, "rd_00", 8'h22);

        // Aborted write after 5 bits leaves the earlier word intact.
        send_cmd(7'h10, 1'b0);
        send_byte(8'h5A);
        end_xfer();
        send_cmd(7'h10, 1'b0);
        for (int i = 7; i >= 3; i--) send_bit(exp_pat[i] ^ 1'b1);
        wait_h();
        cs_pin = 1'b1;
        wait_clk(4);
        check("abort_leds", 32'(leds), 32'h0);
        check("abort_oe", 32'(miso_oe), 32'd0);
        wait_h();
        read_word(7'h10, "rd_10", 8'h5A);

        // CS released mid-read: drive enable and data drop.
        send_cmd(7'h05, 1'b1);
        for (int i = 0; i < 3; i++) begin
            wait_h();
            sclk_pin = 1'b1;
            wait_h();
            sclk_pin = 1'b0;
        end
        cs_pin = 1'b1;
        wait_clk(3);
        check("rdabort_oe", 32'(miso_oe), 32'd0);
        check("rdabort_miso", 32'(miso_pin), 32'd0);
        wait_h();

        // CS release racing the final rising edge of a write still commits.
        send_cmd(7'h30, 1'b0);
        exp_pat = 8'h96;
        for (int i = 7; i >= 1; i--) send_bit(exp_pat[i]);
        mosi_pin = exp_pat[0];
        wait_h();
        sclk_pin = 1'b1;
        wait_clk(2);
        cs_pin = 1'b1;
        wait_h();
        sclk_pin = 1'b0;
        wait_h();
        read_word(7'h30, "rd_30", 8'h96);

        // Reset in the middle of a read burst.
        send_cmd(7'h05, 1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_h();
            sclk_pin = 1'b1;
            wait_h();
            sclk_pin = 1'b0;
        end
        rst_n = 1'b0;
        wait_clk(1);
        check("midrst_miso", 32'(miso_pin), 32'd0);
        check("midrst_oe", 32'(miso_oe), 32'd0);
        check("midrst_leds", 32'(leds), 32'h0);
        cs_pin = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_h();
        read_word(7'h05, "rd_05_after_rst", 8'hA5);

        // Fault injection on bit 0 of committed words when enabled.
        fault_pin = 1'b1;
        send_cmd(7'h20, 1'b0);
        send_byte(8'hA4);
        end_xfer();
        fault_pin = 1'b0;
`ifdef SPI_BURST_MEMORY_FAULT_EN
        read_word(7'h20, "rd_20_fault", 8'hA5);
`else
        read_word(7'h20, "rd_20_fault", 8'hA4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
